gpc3103_5_reg: RTL and testbench

//  Registered (3,1,0,3;5) generalized parallel counter (GPC) for multi-operand adder/compressor trees.
//  - Adds three weight-1 bits, one weight-4 bit and three weight-8 bits.
//  - Output is a 5-bit binary sum; inputs are the bit columns 0, 2 and 3 of a partial-product array.
//  - Pipelined leaf cell: the tree generator instantiates it many times per compression stage.

---
 rtl/gpc_pkg.sv | 25 ++
 rtl/gpc_fa.sv | 16 +
 rtl/gpc3103_5_reg.sv | 75 +++++++
 tb/tb_gpc3103_5_reg.sv | 135 +++++++++++++
 4 files changed

// File: rtl/gpc_pkg.sv
// rtl/gpc_pkg.sv - shared constants for the (3,1,0,3;5) GPC leaf cell; GPC3103_IN_REG_EN selects latency
package gpc_pkg;

    localparam int GPC3103_SRC0_W = 3;
    localparam int GPC3103_SRC2_W = 1;
    localparam int GPC3103_SRC3_W = 3;
    localparam int GPC3103_DST_W  = 5;

    localparam int W0 = 1;
    localparam int W2 = 4;
    localparam int W3 = 8;

`ifdef GPC3103_IN_REG_EN
    localparam int GPC3103_LAT = 2;
`else
    localparam int GPC3103_LAT = 1;
`endif

    typedef struct packed {
        logic [GPC3103_SRC3_W-1:0] src3;
        logic [GPC3103_SRC2_W-1:0] src2;
        logic [GPC3103_SRC0_W-1:0] src0;
    } gpc3103_in_t;

endpackage

// File: rtl/gpc_fa.sv
// rtl/gpc_fa.sv - single-bit full adder used for the weight-1 and weight-8 columns
module gpc_fa (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic co_o
);

    logic ab_x;

    assign ab_x = a_i ^ b_i;
    assign s_o  = ab_x ^ c_i;
    assign co_o = (a_i & b_i) | (c_i & ab_x);

endmodule

// File: rtl/gpc3103_5_reg.sv
// rtl/gpc3103_5_reg.sv - registered (3,1,0,3;5) GPC; GPC3103_IN_REG_EN adds an input register stage
module gpc3103_5_reg
    import gpc_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      vld_i,
    input  logic [GPC3103_SRC0_W-1:0] src0,
    input  logic [GPC3103_SRC2_W-1:0] src2,
    input  logic [GPC3103_SRC3_W-1:0] src3,
    output logic                      vld_o,
    output logic [GPC3103_DST_W-1:0]  dst
);

    gpc3103_in_t                in_w;
    logic                       vld_w;
    logic                       s0_w, c1_w, s3_w, c4_w;
    logic [GPC3103_DST_W-1:0]   dst_d, dst_q;
    logic                       vld_d, vld_q;

`ifdef GPC3103_IN_REG_EN
    gpc3103_in_t in_q;
    logic        in_vld_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_q     <= '0;
            in_vld_q <= 1'b0;
        end else begin
            in_q     <= '{src3: src3, src2: src2, src0: src0};
            in_vld_q <= vld_i;
        end
    end

    assign in_w  = in_q;
    assign vld_w = in_vld_q;
`else
    assign in_w  = '{src3: src3, src2: src2, src0: src0};
    assign vld_w = vld_i;
`endif

    gpc_fa u_fa_col0 (
        .a_i  (in_w.src0[0]),
        .b_i  (in_w.src0[1]),
        .c_i  (in_w.src0[2]),
        .s_o  (s0_w),
        .co_o (c1_w)
    );

    gpc_fa u_fa_col3 (
        .a_i  (in_w.src3[0]),
        .b_i  (in_w.src3[1]),
        .c_i  (in_w.src3[2]),
        .s_o  (s3_w),
        .co_o (c4_w)
    );

    // The groups never carry into each other, so the sum is pure wiring.
    assign dst_d = {c4_w, s3_w, in_w.src2[0], c1_w, s0_w};
    assign vld_d = vld_w;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dst_q <= '0;
            vld_q <= 1'b0;
        end else begin
            dst_q <= dst_d;
            vld_q <= vld_d;
        end
    end

    assign dst   = dst_q;
    assign vld_o = vld_q;

endmodule

// File: tb/tb_gpc3103_5_reg.sv
// tb/tb_gpc3103_5_reg.sv - self-checking bench for gpc3103_5_reg
module tb_gpc3103_5_reg;
    import gpc_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       vld_i;
    logic [2:0] src0;
    logic [0:0] src2;
    logic [2:0] src3;
    logic       vld_o;
    logic [4:0] dst;

    int pass_cnt = 0;
    int total    = 0;

    typedef struct {
        logic [4:0] d;
        logic       v;
        string      name;
    } exp_t;

    typedef struct {
        logic [6:0] vin;
        logic [4:0] exp;
        string      name;
    } vec_t;

    exp_t exp_q[$];
    vec_t tbl[$];

    gpc3103_5_reg dut (
        .clk   (clk),
        .rst   (rst),
        .vld_i (vld_i),
        .src0  (src0),
        .src2  (src2),
        .src3  (src3),
        .vld_o (vld_o),
        .dst   (dst)
    );

    always #5 clk = ~clk;

    // vin packs {src3, src2, src0}
    function automatic logic [4:0] model(input logic [6:0] v);
        int s = 0;
        for (int i = 0; i < 3; i++) s += 1 * int'(v[i]);
        s += 4 * int'(v[3]);
        for (int i = 0; i < 3; i++) s += 8 * int'(v[4+i]);
        return 5'(s);
    endfunction

    task automatic check(input string name, input logic [4:0] ad, input logic av,
                         input logic [4:0] ed, input logic ev);
        total++;
        if (ad === ed && av === ev) pass_cnt++;
        else $display("FAIL %s: dst=%0d vld_o=%0b, expected dst=%0d vld_o=%0b", name, ad, av, ed, ev);
    endtask

    task automatic step(input logic [6:0] v, input logic vld, input logic [4:0] e, input string name);
        exp_t x;
        @(negedge clk);
        if (exp_q.size() == GPC3103_LAT) begin
            x = exp_q.pop_front();
            check(x.name, dst, vld_o, x.d, x.v);
        end
        {src3, src2, src0} = v;
        vld_i = vld;
        exp_q.push_back('{d: e, v: vld, name: name});
    endtask

    task automatic drain();
        repeat (GPC3103_LAT) step(7'h00, 1'b0, 5'd0, "drain");
    endtask

    initial begin
        logic [6:0] r;
        rst = 1'b1; vld_i = 1'b0; src0 = '0; src2 = '0; src3 = '0;
        #1;
        check("reset_state", dst, vld_o, 5'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        tbl.push_back('{vin: {3'b000, 1'b0, 3'b101}, exp: 5'd2,  name: "spot_src0_101"});
        tbl.push_back('{vin: {3'b011, 1'b1, 3'b000}, exp: 5'd20, name: "spot_src2_src3_011"});
        tbl.push_back('{vin: {3'b111, 1'b1, 3'b111}, exp: 5'd31, name: "spot_all_ones"});
        tbl.push_back('{vin: {3'b100, 1'b0, 3'b000}, exp: 5'd8,  name: "spot_src3_100"});
        tbl.push_back('{vin: 7'h00,                  exp: 5'd0,  name: "spot_all_zero"});
        foreach (tbl[i]) step(tbl[i].vin, 1'b1, tbl[i].exp, tbl[i].name);
        drain();

        for (int v = 0; v < 128; v++) step(7'(v), 1'b1, model(7'(v)), "exhaustive");
        drain();

        step(7'h7f, 1'b1, model(7'h7f), "b2b_7f");
        step(7'h00, 1'b1, model(7'h00), "b2b_00");
        step(7'h55, 1'b1, model(7'h55), "b2b_55");
        drain();

        step(7'h12, 1'b0, model(7'h12), "vld_pre");
        step(7'h3c, 1'b1, model(7'h3c), "vld_pulse");
        step(7'h41, 1'b0, model(7'h41), "vld_post1");
        step(7'h66, 1'b0, model(7'h66), "vld_post2");
        drain();

        for (int i = 0; i < 300; i++) begin
            r = 7'($urandom_range(0, 127));
            step(r, 1'($urandom_range(0, 1)), model(r), "random");
        end
        drain();

        // Mid-stream reset with nonzero inputs held
        step(7'h7f, 1'b1, model(7'h7f), "pre_rst_a");
        step(7'h6b, 1'b1, model(7'h6b), "pre_rst_b");
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_clear", dst, vld_o, 5'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_held", dst, vld_o, 5'd0, 1'b0);
        exp_q.delete();
        @(negedge clk);
        check("rst_held_negedge", dst, vld_o, 5'd0, 1'b0);
        rst = 1'b0;
        step(7'h2d, 1'b1, model(7'h2d), "post_rst_first");
        step(7'h77, 1'b1, model(7'h77), "post_rst_second");
        drain();

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
